// File: rtl/cv_pkg.sv
// Shared types and defaults for the CV frame conditioner.
package cv_pkg;

  localparam int unsigned CV_CHANNELS        = 7;
  localparam int unsigned CV_WIDTH           = 16;
  localparam int unsigned CH_W               = $clog2(CV_CHANNELS);
  localparam int unsigned DEF_SMOOTH_SHIFT   = 2;
  localparam int unsigned DEF_TIMEOUT_CYCLES = 240000;

  typedef logic [CV_WIDTH-1:0] cv_word_t;

  typedef enum logic [2:0] {
    IDLE,
    SETTLE,
    CAPTURE,
    FILTER,
    DONE
  } cv_state_e;

endpackage

// File: rtl/cv_smooth_step.sv
// Single-channel first-order IIR step: y moves toward x by (x-y)/2^SHIFT,
// never less than one LSB, so the filter always lands exactly on x.
module cv_smooth_step
  import cv_pkg::*;
#(
  parameter int unsigned SHIFT = DEF_SMOOTH_SHIFT
) (
  input  cv_word_t y,
  input  cv_word_t x,
  output cv_word_t y_new_c
);

  localparam logic signed [CV_WIDTH:0] PLUS_ONE  = (CV_WIDTH+1)'(1);
  localparam logic signed [CV_WIDTH:0] MINUS_ONE = '1;

  logic signed [CV_WIDTH:0] d_c;
  logic signed [CV_WIDTH:0] s_c;
  logic signed [CV_WIDTH:0] sum_c;

  always_comb begin
    d_c = $signed({1'b0, x}) - $signed({1'b0, y});
    s_c = d_c >>> SHIFT;
    if ((d_c != '0) && (s_c == '0)) begin
      s_c = d_c[CV_WIDTH] ? MINUS_ONE : PLUS_ONE;
    end
    sum_c   = $signed({1'b0, y}) + s_c;
    y_new_c = CV_WIDTH'(sum_c);
  end

endmodule

// File: rtl/cv_frame_conditioner.sv
// Captures SPI CV frames into the i_Clock domain, smooths them per channel and
// presents a coherent registered CV set with a valid strobe and link-stale flag.
module cv_frame_conditioner
  import cv_pkg::*;
#(
  parameter int unsigned SMOOTH_SHIFT   = DEF_SMOOTH_SHIFT,
  parameter int unsigned TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
  input  logic                   i_Clock,
  input  logic                   i_Reset_n,
  input  logic                   i_Data_Received,
  input  logic [CV_WIDTH-1:0]    i_Data0,
  input  logic [CV_WIDTH-1:0]    i_Data1,
  input  logic [CV_WIDTH-1:0]    i_Data2,
  input  logic [CV_WIDTH-1:0]    i_Data3,
  input  logic [CV_WIDTH-1:0]    i_Data4,
  input  logic [CV_WIDTH-1:0]    i_Data5,
  input  logic [CV_WIDTH-1:0]    i_Data6,
  input  logic [CV_CHANNELS-1:0] i_Smooth_En,
  output logic [CV_WIDTH-1:0]    o_CV0,
  output logic [CV_WIDTH-1:0]    o_CV1,
  output logic [CV_WIDTH-1:0]    o_CV2,
  output logic [CV_WIDTH-1:0]    o_CV3,
  output logic [CV_WIDTH-1:0]    o_CV4,
  output logic [CV_WIDTH-1:0]    o_CV5,
  output logic [CV_WIDTH-1:0]    o_CV6,
  output logic                   o_CV_Valid,
  output logic                   o_Stale,
  output logic                   o_Overrun
);

  localparam int unsigned       TW      = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TW-1:0]     T_MAX   = TW'(TIMEOUT_CYCLES);
  localparam logic [CH_W-1:0]   LAST_CH = CH_W'(CV_CHANNELS - 1);

  cv_state_e                          state_q, state_d;
  logic [CH_W-1:0]                    ch_q, ch_d;
  logic                               pending_q, pending_d;
  logic                               overrun_q, overrun_d;
  logic                               first_q, first_d;
  logic [2:0]                         sync_q;
  logic [CV_CHANNELS-1:0][CV_WIDTH-1:0] x_q, y_q, cv_q;
  logic                               cv_valid_q, stale_q;
  logic [TW-1:0]                      tmo_q;
  logic                               rise_c, cap_c, filt_c, done_c;
  cv_word_t                           x_sel_c, y_sel_c, step_c, y_upd_c;

  assign rise_c = sync_q[1] & ~sync_q[2];

  // Shared filter datapath, muxed onto the channel being processed
  assign x_sel_c = x_q[ch_q];
  assign y_sel_c = y_q[ch_q];

  cv_smooth_step #(.SHIFT(SMOOTH_SHIFT)) u_step (
    .y       (y_sel_c),
    .x       (x_sel_c),
    .y_new_c (step_c)
  );

  assign y_upd_c = (!i_Smooth_En[ch_q] || first_q) ? x_sel_c : step_c;

  // Next-state and control
  always_comb begin
    state_d   = state_q;
    ch_d      = ch_q;
    pending_d = pending_q;
    overrun_d = overrun_q;
    first_d   = first_q;
    cap_c     = 1'b0;
    filt_c    = 1'b0;
    done_c    = 1'b0;

    if (rise_c && (state_q != IDLE)) begin
      if (pending_q) overrun_d = 1'b1;
      else           pending_d = 1'b1;
    end

    case (state_q)
      IDLE:    if (rise_c) state_d = SETTLE;
      SETTLE:  state_d = CAPTURE;
      CAPTURE: begin
        cap_c   = 1'b1;
        ch_d    = '0;
        state_d = FILTER;
      end
      FILTER: begin
        filt_c = 1'b1;
        if (ch_q == LAST_CH) state_d = DONE;
        else                 ch_d    = ch_q + CH_W'(1);
      end
      DONE: begin
        done_c    = 1'b1;
        first_d   = 1'b0;
        pending_d = 1'b0;
        state_d   = (pending_q || rise_c) ? SETTLE : IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge i_Clock or negedge i_Reset_n) begin
    if (!i_Reset_n) begin
      state_q    <= IDLE;
      ch_q       <= '0;
      pending_q  <= 1'b0;
      overrun_q  <= 1'b0;
      first_q    <= 1'b1;
      sync_q     <= '0;
      x_q        <= '0;
      y_q        <= '0;
      cv_q       <= '0;
      cv_valid_q <= 1'b0;
      stale_q    <= 1'b1;
      tmo_q      <= '0;
    end else begin
      state_q    <= state_d;
      ch_q       <= ch_d;
      pending_q  <= pending_d;
      overrun_q  <= overrun_d;
      first_q    <= first_d;
      sync_q     <= {sync_q[1:0], i_Data_Received};
      cv_valid_q <= done_c;
      if (cap_c) x_q <= {i_Data6, i_Data5, i_Data4, i_Data3, i_Data2, i_Data1, i_Data0};
      if (filt_c) y_q[ch_q] <= y_upd_c;
      if (done_c) cv_q <= y_q;
      // Stale timer saturates; only a completed frame clears it
      if (done_c) begin
        tmo_q   <= '0;
        stale_q <= 1'b0;
      end else if (tmo_q != T_MAX) begin
        tmo_q <= tmo_q + TW'(1);
        if (tmo_q == (T_MAX - TW'(1))) stale_q <= 1'b1;
      end
    end
  end

  assign o_CV0      = cv_q[0];
  assign o_CV1      = cv_q[1];
  assign o_CV2      = cv_q[2];
  assign o_CV3      = cv_q[3];
  assign o_CV4      = cv_q[4];
  assign o_CV5      = cv_q[5];
  assign o_CV6      = cv_q[6];
  assign o_CV_Valid = cv_valid_q;
  assign o_Stale    = stale_q;
  assign o_Overrun  = overrun_q;

endmodule

// File: tb/tb_cv_frame_conditioner.sv
// Directed self-checking bench for cv_frame_conditioner (short stale timeout).
module tb_cv_frame_conditioner;

  localparam int unsigned TO = 100;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        drq;
  logic [15:0] d  [7];
  logic [15:0] cv [7];
  logic [6:0]  en;
  logic        valid, stale, overrun;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  cv_frame_conditioner #(.SMOOTH_SHIFT(2), .TIMEOUT_CYCLES(TO)) dut (
    .i_Clock         (clk),
    .i_Reset_n       (rst_n),
    .i_Data_Received (drq),
    .i_Data0         (d[0]),
    .i_Data1         (d[1]),
    .i_Data2         (d[2]),
    .i_Data3         (d[3]),
    .i_Data4         (d[4]),
    .i_Data5         (d[5]),
    .i_Data6         (d[6]),
    .i_Smooth_En     (en),
    .o_CV0           (cv[0]),
    .o_CV1           (cv[1]),
    .o_CV2           (cv[2]),
    .o_CV3           (cv[3]),
    .o_CV4           (cv[4]),
    .o_CV5           (cv[5]),
    .o_CV6           (cv[6]),
    .o_CV_Valid      (valid),
    .o_Stale         (stale),
    .o_Overrun       (overrun)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One frame: flag high for edges 1-2, valid expected only after edge 13
  task automatic run_frame();
    drq = 1'b1;
    for (int i = 1; i <= 13; i++) begin
      tick();
      if (i == 2) drq = 1'b0;
      if (i == 12) check("valid_pre", valid, 0);
    end
    check("valid_at13", valid, 1);
    tick();
    check("valid_after", valid, 0);
  endtask

  // Extra one-cycle flag pulses raised after ticks p2 / p3; valids at 13 and 23
  task automatic back_to_back(input int p2, input int p3, input logic exp_ovr);
    drq = 1'b1;
    for (int t = 1; t <= 40; t++) begin
      tick();
      drq = (t == p2) || (t == p3);
      check("valid_bb", valid, (t == 13) || (t == 23));
    end
    check("overrun_bb", overrun, exp_ovr);
  endtask

  initial begin
    rst_n = 1'b0;
    drq   = 1'b0;
    en    = 7'h7F;
    for (int k = 0; k < 7; k++) d[k] = 16'h0;
    #12;
    check("rst_cv0", cv[0], 16'h0);
    check("rst_cv6", cv[6], 16'h0);
    check("rst_valid", valid, 0);
    check("rst_stale", stale, 1);
    check("rst_overrun", overrun, 0);
    tick();
    rst_n = 1'b1;
    tick();

    // First frame passes through unsmoothed
    for (int k = 0; k < 7; k++) d[k] = 16'(16'h1000 * (k + 1));
    check("stale_before_first", stale, 1);
    run_frame();
    check("ff_cv0", cv[0], 16'h1000);
    check("ff_cv1", cv[1], 16'h2000);
    check("ff_cv2", cv[2], 16'h3000);
    check("ff_cv3", cv[3], 16'h4000);
    check("ff_cv4", cv[4], 16'h5000);
    check("ff_cv5", cv[5], 16'h6000);
    check("ff_cv6", cv[6], 16'h7000);
    check("ff_stale", stale, 0);

    // Smoothing from 0 toward 0x4000
    en = 7'h7E; d[0] = 16'h0000;
    run_frame();
    check("sm_zero", cv[0], 16'h0000);
    en = 7'h7F; d[0] = 16'h4000;
    run_frame();
    check("sm_1", cv[0], 16'h1000);
    run_frame();
    check("sm_2", cv[0], 16'h1C00);
    run_frame();
    check("sm_3", cv[0], 16'h2500);
    for (int f = 0; f < 42; f++) run_frame();
    check("sm_conv", cv[0], 16'h4000);
    d[0] = 16'h4002;
    run_frame();
    check("sm_up1", cv[0], 16'h4001);
    run_frame();
    check("sm_up2", cv[0], 16'h4002);
    d[0] = 16'h3FFF;
    run_frame();
    check("sm_dn1", cv[0], 16'h4001);

    // Bypass vs smoothed channel on a full-scale step
    en = 7'h7C; d[0] = 16'h0000; d[1] = 16'h0000;
    run_frame();
    check("bp_base1", cv[1], 16'h0000);
    en = 7'h7E; d[0] = 16'hFFFF; d[1] = 16'hFFFF;
    run_frame();
    check("bp_cv0", cv[0], 16'hFFFF);
    check("bp_cv1", cv[1], 16'h3FFF);

    // Back-to-back frames: during FILTER, during DONE, then a third rise
    back_to_back(5, -1, 1'b0);
    back_to_back(10, -1, 1'b0);
    back_to_back(5, 8, 1'b1);

    // Stale timeout and recovery
    en = 7'h00; d[0] = 16'h2000;
    run_frame();
    check("st_cv0", cv[0], 16'h2000);
    for (int k = 1; k <= 98; k++) tick();
    check("st_not_yet", stale, 0);
    tick();
    check("st_set", stale, 1);
    check("st_hold", cv[0], 16'h2000);
    en = 7'h7F; d[0] = 16'h6000;
    run_frame();
    check("st_clear", stale, 0);
    check("st_resume", cv[0], 16'h3000);

    // Reset in the middle of FILTER (channel 3)
    d[0] = 16'h8000; d[1] = 16'h2000;
    drq = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      tick();
      if (i == 2) drq = 1'b0;
    end
    rst_n = 1'b0;
    #1;
    check("mr_cv0", cv[0], 16'h0);
    check("mr_cv6", cv[6], 16'h0);
    check("mr_valid", valid, 0);
    check("mr_stale", stale, 1);
    check("mr_overrun", overrun, 0);
    tick();
    rst_n = 1'b1;
    tick();
    run_frame();
    check("mr_first_cv0", cv[0], 16'h8000);
    check("mr_first_cv1", cv[1], 16'h2000);
    check("mr_stale_clr", stale, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
